// File: rtl/burst_ram_if.sv
// Burst RAM controller bus: request channel, write-beat channel, read-beat channel, status.
//   master : drives req_*, wr_data/wr_valid, rd_ready; observes ready/valid/status.
//   slave  : the controller side (opposite directions).
interface burst_ram_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned LEN_W  = 8
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              busy;
    logic              done;

    modport master (
        output req_valid, req_write, req_addr, req_len, wr_data, wr_valid, rd_ready,
        input  req_ready, wr_ready, rd_data, rd_valid, busy, done
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_len, wr_data, wr_valid, rd_ready,
        output req_ready, wr_ready, rd_data, rd_valid, busy, done
    );
endinterface

// File: rtl/burst_ram_ctrl.sv
// Burst RAM controller: single-port RAM of 2**ADDR_W words, zeroed after reset,
// accessed by write/read bursts of req_len+1 beats with wrapping addresses.
// Ports: clk, RST (sync, active-high), bus (burst_ram_if.slave: request, write
// beats, read beats with 1-cycle registered read, busy/done status).
module burst_ram_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned LEN_W  = 8
) (
    input  logic           clk,
    input  logic           RST,
    burst_ram_if.slave     bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned ISS_W = LEN_W + 1;

    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_WRITE, ST_READ} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ISS_W-1:0]  iss_cnt_q, iss_cnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              req_ready_q, req_ready_d;
    logic              wr_ready_q, wr_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [DATA_W-1:0] mem_wdata_c;

    logic clr_last_c;
    logic beat_last_c;
    logic rd_xfer_c;
    logic rd_issue_c;

    assign clr_last_c  = &clr_cnt_q;
    assign beat_last_c = (beat_cnt_q == len_q);
    assign rd_xfer_c   = rd_valid_q & bus.rd_ready;
    // Issue a RAM read only while beats remain and the output register is free or draining.
    assign rd_issue_c  = (state_q == ST_READ) && (iss_cnt_q <= {1'b0, len_q})
                         && (!rd_valid_q || bus.rd_ready);

    // State register
    always_ff @(posedge clk) begin
        if (RST) state_q <= ST_CLEAR;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_last_c)                 state_d = ST_IDLE;
            ST_IDLE:  if (bus.req_valid)              state_d = bus.req_write ? ST_WRITE : ST_READ;
            ST_WRITE: if (bus.wr_valid && beat_last_c) state_d = ST_IDLE;
            ST_READ:  if (rd_xfer_c && beat_last_c)   state_d = ST_IDLE;
            default:                                  state_d = ST_CLEAR;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        clr_cnt_d   = clr_cnt_q;
        addr_d      = addr_q;
        len_d       = len_q;
        beat_cnt_d  = beat_cnt_q;
        iss_cnt_d   = iss_cnt_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        done_d      = 1'b0;
        mem_we_c    = 1'b0;
        mem_waddr_c = addr_q;
        mem_wdata_c = bus.wr_data;
        case (state_q)
            ST_CLEAR: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = clr_cnt_q;
                mem_wdata_c = '0;
                clr_cnt_d   = clr_cnt_q + ADDR_W'(1);
                done_d      = clr_last_c;
            end
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_d     = bus.req_addr;
                    len_d      = bus.req_len;
                    beat_cnt_d = '0;
                    iss_cnt_d  = '0;
                end
            end
            ST_WRITE: begin
                if (bus.wr_valid) begin
                    mem_we_c   = 1'b1;
                    addr_d     = addr_q + ADDR_W'(1);
                    beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    done_d     = beat_last_c;
                end
            end
            ST_READ: begin
                if (rd_issue_c) begin
                    rd_data_d  = mem[addr_q];
                    rd_valid_d = 1'b1;
                    addr_d     = addr_q + ADDR_W'(1);
                    iss_cnt_d  = iss_cnt_q + ISS_W'(1);
                end else if (rd_xfer_c) begin
                    rd_valid_d = 1'b0;
                end
                if (rd_xfer_c) begin
                    beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    done_d     = beat_last_c;
                end
            end
            default: ;
        endcase
        req_ready_d = (state_d == ST_IDLE);
        wr_ready_d  = (state_d == ST_WRITE);
        busy_d      = (state_d != ST_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (RST) begin
            clr_cnt_q   <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            iss_cnt_q   <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            req_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            clr_cnt_q   <= clr_cnt_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            iss_cnt_q   <= iss_cnt_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            req_ready_q <= req_ready_d;
            wr_ready_q  <= wr_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // RAM write port; reset blocks any write in the same cycle
    always_ff @(posedge clk) begin
        if (!RST && mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
    end

    assign bus.req_ready = req_ready_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_burst_ram_ctrl.sv
// Self-checking bench for burst_ram_ctrl (DATA_W=8, ADDR_W=4, LEN_W=4) with an
// array reference model of RAM contents.
module tb_burst_ram_ctrl;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned DEPTH  = 16;

    logic clk = 1'b0;
    logic RST;
    always #5 clk = ~clk;

    burst_ram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    burst_ram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] ref_mem [DEPTH];

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.wr_data   = '0;
        bus.wr_valid  = 1'b0;
        bus.rd_ready  = 1'b0;
    endtask

    // Sampled right after a reset edge with RST released.
    task automatic check_reset_outputs(input string tag);
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL %s_busy got=%b exp=1", tag, bus.busy); else n_pass++;
        n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL %s_req_ready got=%b exp=0", tag, bus.req_ready); else n_pass++;
        n_checks++; if (bus.wr_ready !== 1'b0) $display("FAIL %s_wr_ready got=%b exp=0", tag, bus.wr_ready); else n_pass++;
        n_checks++; if (bus.rd_valid !== 1'b0) $display("FAIL %s_rd_valid got=%b exp=0", tag, bus.rd_valid); else n_pass++;
        n_checks++; if (bus.rd_data !== 8'h00) $display("FAIL %s_rd_data got=%h exp=00", tag, bus.rd_data); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL %s_done got=%b exp=0", tag, bus.done); else n_pass++;
    endtask

    // Counts busy cycles of the clear sweep; RAM becomes all zero.
    task automatic wait_clear(input string tag);
        int cyc = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++; if (cyc != DEPTH) $display("FAIL %s_clear_cycles got=%0d exp=%0d", tag, cyc, DEPTH); else n_pass++;
        n_checks++; if (bus.done !== 1'b1) $display("FAIL %s_clear_done got=%b exp=1", tag, bus.done); else n_pass++;
        n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL %s_clear_req_ready got=%b exp=1", tag, bus.req_ready); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) $display("FAIL %s_done_pulse_width got=%b exp=0", tag, bus.done); else n_pass++;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic start_req(input bit wr, input int addr, input int len, input string tag);
        int w = 0;
        while (bus.req_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        n_checks++; if (w >= 50) $display("FAIL %s_req_timeout got=%b exp=1", tag, bus.req_ready); else n_pass++;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = ADDR_W'(addr);
        bus.req_len   = LEN_W'(len);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = ADDR_W'($urandom);
        bus.req_len   = LEN_W'($urandom);
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL %s_busy_after_req got=%b exp=1", tag, bus.busy); else n_pass++;
    endtask

    task automatic write_burst(input int addr, input int len, input logic [7:0] d[$], input bit gaps, input string tag);
        start_req(1'b1, addr, len, tag);
        n_checks++; if (bus.wr_ready !== 1'b1) $display("FAIL %s_wr_ready got=%b exp=1", tag, bus.wr_ready); else n_pass++;
        for (int i = 0; i <= len; i++) begin
            while (gaps && $urandom_range(0, 2) == 0) begin
                bus.wr_valid = 1'b0;
                bus.wr_data  = 8'($urandom);
                @(negedge clk);
            end
            bus.wr_valid = 1'b1;
            bus.wr_data  = d[i];
            @(negedge clk);
            ref_mem[(addr + i) % DEPTH] = d[i];
        end
        bus.wr_valid = 1'b0;
        n_checks++; if (bus.done !== 1'b1) $display("FAIL %s_wr_done got=%b exp=1", tag, bus.done); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL %s_wr_idle got=%b exp=0", tag, bus.busy); else n_pass++;
        n_checks++; if (bus.wr_ready !== 1'b0) $display("FAIL %s_wr_ready_end got=%b exp=0", tag, bus.wr_ready); else n_pass++;
    endtask

    // mode 0: rd_ready always 1; mode 1: 1,0,0 repeating; mode 2: random.
    task automatic read_burst(input int addr, input int len, input int mode, input string tag);
        logic [7:0] exp_q[$];
        logic [7:0] prev_data = 8'h00;
        bit prev_stall = 1'b0;
        bit rdy;
        int got = 0;
        int cyc = 0;
        int n = len + 1;
        for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[(addr + i) % DEPTH]);
        start_req(1'b0, addr, len, tag);
        while (got < n && cyc < 300) begin
            if (prev_stall) begin
                n_checks++;
                if (bus.rd_valid !== 1'b1 || bus.rd_data !== prev_data)
                    $display("FAIL %s_stall_hold got=%b/%h exp=1/%h", tag, bus.rd_valid, bus.rd_data, prev_data);
                else n_pass++;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.rd_ready = rdy;
            if (bus.rd_valid === 1'b1 && rdy) begin
                n_checks++;
                if (bus.rd_data !== exp_q[got])
                    $display("FAIL %s_beat%0d got=%h exp=%h", tag, got, bus.rd_data, exp_q[got]);
                else n_pass++;
                got++;
            end
            prev_stall = (bus.rd_valid === 1'b1) && !rdy;
            prev_data  = bus.rd_data;
            @(negedge clk);
            cyc++;
        end
        bus.rd_ready = 1'b0;
        n_checks++; if (got != n) $display("FAIL %s_beat_count got=%0d exp=%0d", tag, got, n); else n_pass++;
        n_checks++; if (bus.done !== 1'b1) $display("FAIL %s_rd_done got=%b exp=1", tag, bus.done); else n_pass++;
        n_checks++; if (bus.rd_valid !== 1'b0) $display("FAIL %s_rd_valid_end got=%b exp=0", tag, bus.rd_valid); else n_pass++;
        if (mode == 0) begin
            n_checks++; if (cyc != n + 1) $display("FAIL %s_throughput got=%0d exp=%0d", tag, cyc, n + 1); else n_pass++;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1'b1;
        repeat (3) @(negedge clk);
        RST = 1'b0;
        check_reset_outputs("reset");
        wait_clear("reset");
        read_burst(0, 15, 0, "reset_zero");
    endtask

    task automatic test_back_to_back();
        logic [7:0] d[$] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        write_burst(3, 3, d, 1'b0, "b2b_wr");
        read_burst(3, 3, 0, "b2b_rd");
    endtask

    task automatic test_wrap();
        logic [7:0] d[$] = '{8'h10, 8'h11, 8'h12, 8'h13};
        write_burst(14, 3, d, 1'b0, "wrap_wr");
        read_burst(14, 3, 0, "wrap_rd");
        read_burst(0, 15, 0, "wrap_all");
    endtask

    task automatic test_stall();
        read_burst(3, 3, 1, "stall_toggle");
        read_burst(10, 9, 2, "stall_rand");
    endtask

    task automatic test_ignore();
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hFF;
        bus.rd_ready = 1'b1;
        repeat (5) @(negedge clk);
        bus.rd_ready = 1'b0;
        read_burst(0, 15, 0, "ignore_during_rd");
        bus.wr_valid = 1'b0;
        read_burst(0, 15, 2, "ignore_all");
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            int addr = $urandom_range(0, DEPTH - 1);
            int len  = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                logic [7:0] d[$];
                for (int i = 0; i <= len; i++) d.push_back(8'($urandom));
                write_burst(addr, len, d, 1'b1, $sformatf("rnd%0d_wr", k));
            end else begin
                read_burst(addr, len, 2, $sformatf("rnd%0d_rd", k));
            end
        end
        read_burst(0, 15, 0, "rnd_final");
    endtask

    task automatic test_reset_mid_write();
        start_req(1'b1, 5, 3, "rstw");
        for (int i = 0; i < 2; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'h50 + 8'(i);
            @(negedge clk);
        end
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h77;
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        bus.wr_valid = 1'b0;
        check_reset_outputs("rstw");
        wait_clear("rstw");
        read_burst(0, 15, 0, "rstw_zero");
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d[$] = '{8'h5A, 8'hC3, 8'h3C};
        int w = 0;
        write_burst(7, 2, d, 1'b0, "rstr_wr");
        start_req(1'b0, 7, 2, "rstr");
        bus.rd_ready = 1'b0;
        while (bus.rd_valid !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_checks++; if (w >= 20) $display("FAIL rstr_valid_timeout got=%b exp=1", bus.rd_valid); else n_pass++;
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        check_reset_outputs("rstr");
        wait_clear("rstr");
        read_burst(0, 15, 2, "rstr_zero");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wrap();
        test_stall();
        test_random();
        test_reset_mid_write();
        test_ignore();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/burst_ram_ctrl.md
BURST_RAM_CTRL -- requirements
Module: burst_ram_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 15, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter LEN_W, default 8, burst-length field width.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  burst request present.
REQ-007 req_ready  output  1  controller accepts request this cycle.
REQ-008 req_write  input  1  1 = write burst, 0 = read burst.
REQ-009 req_addr  input  ADDR_W  burst start address.
REQ-010 req_len  input  LEN_W  beats minus one (0 = 1 beat).
REQ-011 wr_data  input  DATA_W  write beat data.
REQ-012 wr_valid  input  1  write beat present.
REQ-013 wr_ready  output  1  write beat accepted.
REQ-014 rd_data  output  DATA_W  read beat data.
REQ-015 rd_valid  output  1  rd_data valid.
REQ-016 rd_ready  input  1  sink accepts read beat.
REQ-017 busy  output  1  state is not IDLE.
REQ-018 done  output  1  one-cycle pulse at end of burst or clear.

Function
REQ-019 SHALL implement states CLEAR, IDLE, WRITE, READ.
REQ-020 CLEAR: one word zeroed per cycle, addresses 0..DEPTH-1 ascending; takes exactly DEPTH cycles, then done=1 for one cycle and state IDLE.
REQ-021 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready; addr, len, write latched on handshake.
REQ-022 WRITE: wr_ready=1; each cycle with wr_valid=1 writes wr_data to current address; address then increments.
REQ-023 READ: memory read latency 1 cycle; rd_data/rd_valid registered; beat transferred when rd_valid & rd_ready.
REQ-024 READ SHALL issue a new memory read only when output register empty or being consumed that cycle; full throughput 1 beat/cycle with rd_ready held high.
REQ-025 rd_data and rd_valid SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-026 Burst address SHALL wrap modulo DEPTH (DEPTH-1 -> 0) without error.
REQ-027 Burst completes after req_len+1 accepted beats; done=1 in cycle after last beat transfers; state returns to IDLE same edge.
REQ-028 Request accepted in IDLE takes effect next cycle; no new request accepted until done pulse.
REQ-029 Write-then-read of same address in consecutive bursts SHALL return the newly written data.
REQ-030 wr_valid outside WRITE and rd_ready outside READ SHALL be ignored; memory unchanged.

Reset
REQ-031 On RST=1 at a rising edge: state CLEAR, clear counter 0, beat counter 0, req_ready=0, wr_ready=0, rd_valid=0, rd_data=0, done=0, busy=1.
REQ-032 RST mid-burst or mid-clear SHALL abort immediately; in-flight beat discarded; full CLEAR restarts from address 0.
REQ-033 RST SHALL take priority over every other input.

Verification (DATA_W=8, ADDR_W=4, LEN_W=4)
REQ-034 RST 1 cycle -> busy=1 for 16 cycles, done pulse, then req_ready=1; reading 16 words returns all 0x00.
REQ-035 Write burst addr=3, len=3, data 0xA1,0xA2,0xA3,0xA4 -> read burst addr=3, len=3 returns same four bytes in order, done after each burst.
REQ-036 Write addr=14, len=3, data 0x10..0x13 -> read addr=14 len=3 returns 0x10..0x13; addresses 14,15,0,1 hold them (wrap).
REQ-037 Read burst len=3 with rd_ready toggling 1,0,0,1,... -> no beat lost or duplicated; rd_data stable while stalled.
REQ-038 Assert RST during beat 2 of a write burst -> outputs at reset values next cycle, full 16-cycle CLEAR, all words read back 0x00.
REQ-039 wr_valid=1 with data 0xFF while IDLE, then read all words -> no word equals 0xFF.
